ex_operand_fwd: RTL

- Parametrised operand-forwarding and load-use hazard unit for the 5-stage pipeline. Generalises the single-operand BusA forwarding mux to NSRC source operands.
- Internally tracks destination tags and results through the EX, M and W stages. Produces forwarded operands for the EX-stage instruction.
- Detects load-use hazards, inserts bubbles, and drives the register-file write-back port.
- Sits between ID/EX pipeline control and the ALU operand inputs.

---
 rtl/ex_operand_fwd.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_operand_fwd.sv
// ---------------------------------------------------------------------------
// ex_operand_fwd
//
// Operand-forwarding and load-use hazard unit for a 5-stage pipeline.
// The unit keeps its own copy of the destination tags and results for the
// EX, M and W stages. From these it builds the NSRC forwarded operands for
// the instruction now in EX. It also raises a one-cycle load-use stall and
// drives the register-file write-back port.
//
// Ports
//   clk            pipeline clock, rising edge
//   rst_n          asynchronous active-low reset
//   hold           global freeze: no stage register changes
//   flush          squash the ID->EX transfer (EX receives a bubble)
//   id_valid       ID holds a valid instruction
//   id_rs          source register numbers, operand i at [i*AW +: AW]
//   id_rs_used     per-source "operand is read" flags
//   id_rf_data     register-file read data, operand i at [i*DW +: DW]
//   id_rd          destination register of the ID instruction
//   id_wr_en       ID instruction writes rd
//   id_is_load     ID instruction is a load
//   ex_alu_result  ALU result of the EX instruction
//   m_load_data    memory read data for the M-stage load (same cycle)
//   ex_op          forwarded operands for the EX instruction
//   ex_fwd_sel     per-operand source: 00 regfile, 01 W, 10 M, 11 illegal
//   load_use_stall freeze PC/IF/ID this cycle
//   wb_valid       register-file write enable
//   wb_rd          write-back register
//   wb_data        write-back data
// ---------------------------------------------------------------------------
module ex_operand_fwd #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NSRC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [NSRC*DW-1:0]   id_rf_data,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    input  logic [DW-1:0]        ex_alu_result,
    input  logic [DW-1:0]        m_load_data,
    output logic [NSRC*DW-1:0]   ex_op,
    output logic [2*NSRC-1:0]    ex_fwd_sel,
    output logic                 load_use_stall,
    output logic                 wb_valid,
    output logic [AW-1:0]        wb_rd,
    output logic [DW-1:0]        wb_data
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_W   = 2'b01;
    localparam logic [1:0] SEL_M   = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    // -----------------------------------------------------------------------
    // Stage registers (per-operand EX fields live in the generate block)
    // -----------------------------------------------------------------------
    logic          ex_v_reg;
    logic [AW-1:0] ex_rd_reg;
    logic          ex_we_reg;
    logic          ex_ld_reg;

    logic          m_v_reg;
    logic [AW-1:0] m_rd_reg;
    logic          m_we_reg;
    logic          m_ld_reg;
    logic [DW-1:0] m_alu_reg;

    logic          w_v_reg;
    logic [AW-1:0] w_rd_reg;
    logic          w_we_reg;
    logic [DW-1:0] w_data_reg;

    // One bit per ID operand that reads the register the EX load produces
    logic [NSRC-1:0] hazard_hit;

    // EX takes the ID instruction only when nothing turns it into a bubble
    logic ex_take;

    // -----------------------------------------------------------------------
    // Load-use detection
    // A load in EX produces its data one stage too late for a dependent
    // instruction in ID. That instruction waits one cycle. It then
    // picks up the load data from W.
    // -----------------------------------------------------------------------
    assign load_use_stall = id_valid && !flush && ex_v_reg && ex_we_reg &&
                            ex_ld_reg && (ex_rd_reg != '0) && (|hazard_hit);

    assign ex_take = id_valid && !flush && !load_use_stall;

    // -----------------------------------------------------------------------
    // Write-back port, taken straight from the W stage registers
    // -----------------------------------------------------------------------
    assign wb_valid = w_v_reg && w_we_reg && (w_rd_reg != '0);
    assign wb_rd    = w_rd_reg;
    assign wb_data  = w_data_reg;

    // -----------------------------------------------------------------------
    // EX stage: shared control fields. A bubble also clears the tags, so a
    // squashed slot cannot look like a producer or a consumer.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_reg  <= 1'b0;
            ex_rd_reg <= '0;
            ex_we_reg <= 1'b0;
            ex_ld_reg <= 1'b0;
        end else if (!hold) begin
            ex_v_reg  <= ex_take;
            ex_rd_reg <= ex_take ? id_rd : '0;
            ex_we_reg <= ex_take && id_wr_en;
            ex_ld_reg <= ex_take && id_is_load;
        end
    end

    // -----------------------------------------------------------------------
    // M stage: EX moves down. The ALU result is sampled here because it is
    // only valid while the instruction sits in EX.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v_reg   <= 1'b0;
            m_rd_reg  <= '0;
            m_we_reg  <= 1'b0;
            m_ld_reg  <= 1'b0;
            m_alu_reg <= '0;
        end else if (!hold) begin
            m_v_reg   <= ex_v_reg;
            m_rd_reg  <= ex_rd_reg;
            m_we_reg  <= ex_we_reg;
            m_ld_reg  <= ex_ld_reg;
            m_alu_reg <= ex_alu_result;
        end
    end

    // -----------------------------------------------------------------------
    // W stage: a load's result is the memory data that arrives while the
    // load is in M. Every other instruction carries its ALU result.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_v_reg    <= 1'b0;
            w_rd_reg   <= '0;
            w_we_reg   <= 1'b0;
            w_data_reg <= '0;
        end else if (!hold) begin
            w_v_reg    <= m_v_reg;
            w_rd_reg   <= m_rd_reg;
            w_we_reg   <= m_we_reg;
            w_data_reg <= m_ld_reg ? m_load_data : m_alu_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Per-operand logic: EX capture, forwarding select and hazard match
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [AW-1:0] id_rs_i;
        logic [DW-1:0] id_rf_i;
        logic [DW-1:0] capture_data;

        logic [AW-1:0] rs_reg;
        logic          used_reg;
        logic [DW-1:0] opraw_reg;

        logic [1:0]    fwd_sel_next;
        logic [DW-1:0] fwd_op_next;

        assign id_rs_i = id_rs[gi*AW +: AW];
        assign id_rf_i = id_rf_data[gi*DW +: DW];

        assign hazard_hit[gi] = id_rs_used[gi] && (id_rs_i == ex_rd_reg);

        // The write-back happens in the same cycle that this operand is read
        // from the register file. The written value is taken here directly,
        // so the register file never needs write-first read behaviour.
        assign capture_data = (wb_valid && (wb_rd == id_rs_i)) ? wb_data
                                                               : id_rf_i;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rs_reg    <= '0;
                used_reg  <= 1'b0;
                opraw_reg <= '0;
            end else if (!hold) begin
                rs_reg    <= ex_take ? id_rs_i : '0;
                used_reg  <= ex_take && id_rs_used[gi];
                opraw_reg <= ex_take ? capture_data : '0;
            end
        end

        // The youngest producer wins: M is checked before W. A load in M
        // that matches cannot happen, because the load-use stall keeps the
        // consumer in ID for that cycle. If it does happen, the operand is
        // tagged 11 and zeroed rather than given stale data.
        always_comb begin
            fwd_sel_next = SEL_RF;
            fwd_op_next  = opraw_reg;
            if (ex_v_reg && used_reg && (rs_reg != '0)) begin
                if (m_v_reg && m_we_reg && (m_rd_reg == rs_reg)) begin
                    if (!m_ld_reg) begin
                        fwd_sel_next = SEL_M;
                        fwd_op_next  = m_alu_reg;
                    end else begin
                        fwd_sel_next = SEL_ILL;
                        fwd_op_next  = '0;
                    end
                end else if (w_v_reg && w_we_reg && (w_rd_reg == rs_reg)) begin
                    fwd_sel_next = SEL_W;
                    fwd_op_next  = w_data_reg;
                end
            end
        end

        assign ex_fwd_sel[2*gi +: 2] = fwd_sel_next;
        assign ex_op[gi*DW +: DW]    = fwd_op_next;
    end

endmodule
